// File: rtl/aes_shiftrows_serial.sv
// Byte-serial forward AES ShiftRows: fill 16 bytes, then replay them in shifted order.
// Optional inverse ordering via `AES_SR_INV_MODE_EN (adds the inv_mode input).
module aes_shiftrows_serial #(
    parameter int BYTE_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [BYTE_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [BYTE_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
`ifdef AES_SR_INV_MODE_EN
    input  logic              inv_mode,
`endif
    output logic              blk_done
);

    typedef enum logic {FILL, DRAIN} state_t;

    state_t            state, state_nx;
    logic [3:0]        wr_cnt, rd_cnt, rd_nx;
    logic [BYTE_W-1:0] mem [16];
    logic              in_acc, out_acc;
    logic              inv_sel;

    // Source index: column shifted by +r (forward) or -r (inverse), row kept.
    function automatic logic [3:0] src_idx(input logic [3:0] idx, input logic inv);
        logic [1:0] r, c, col;
        r   = idx[1:0];
        c   = idx[3:2];
        col = inv ? (c - r) : (c + r);
        return {col, r};
    endfunction

    assign in_acc  = (state == FILL) && in_valid;
    assign out_acc = (state == DRAIN) && out_ready;
    assign rd_nx   = rd_cnt + 4'd1;

`ifdef AES_SR_INV_MODE_EN
    logic inv_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            inv_q <= 1'b0;
        else if (in_acc && wr_cnt == 4'd0)
            inv_q <= inv_mode;
    end
    assign inv_sel = inv_q;
`else
    assign inv_sel = 1'b0;
`endif

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            FILL: begin
                in_ready = 1'b1;
                busy     = (wr_cnt != 4'd0);
                if (in_acc && wr_cnt == 4'd15)
                    state_nx = DRAIN;
            end
            DRAIN: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                if (out_acc && rd_cnt == 4'd15)
                    state_nx = FILL;
            end
            default: state_nx = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (in_acc)
            mem[wr_cnt] <= in_data;
    end

    // out_data is preloaded with the first shifted byte on the last fill accept,
    // then advanced on each downstream accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= FILL;
            wr_cnt   <= '0;
            rd_cnt   <= '0;
            out_data <= '0;
            blk_done <= 1'b0;
        end else begin
            state    <= state_nx;
            blk_done <= out_acc && (rd_cnt == 4'd15);
            if (in_acc) begin
                wr_cnt <= wr_cnt + 4'd1;
                if (wr_cnt == 4'd15)
                    out_data <= mem[src_idx(4'd0, inv_sel)];
            end
            if (out_acc) begin
                rd_cnt <= rd_nx;
                if (rd_cnt == 4'd15)
                    out_data <= '0;
                else
                    out_data <= mem[src_idx(rd_nx, inv_sel)];
            end
        end
    end

endmodule

// File: tb/tb_aes_shiftrows_serial.sv
// Directed bench for aes_shiftrows_serial: table of input bytes with expected shifted outputs.
module tb_aes_shiftrows_serial;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       busy;
    logic       blk_done;
`ifdef AES_SR_INV_MODE_EN
    logic       inv_mode;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [7:0] din;
        logic [7:0] exp_fwd;
        logic [7:0] exp_inv;
    } vec_t;

    vec_t tbl [16];

    always #5 clk = ~clk;

    aes_shiftrows_serial #(.BYTE_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
`ifdef AES_SR_INV_MODE_EN
        .inv_mode  (inv_mode),
`endif
        .blk_done  (blk_done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " in_ready"},  32'(in_ready),  32'd1);
        check({tag, " out_valid"}, 32'(out_valid), 32'd0);
        check({tag, " busy"},      32'(busy),      32'd0);
        check({tag, " blk_done"},  32'(blk_done),  32'd0);
        check({tag, " out_data"},  32'(out_data),  32'd0);
    endtask

    // Fill 16 bytes (base + table input), then drain and compare against the table.
    task automatic run_block(input logic [7:0] base, input bit toggle, input bit garbage,
                             input bit inv);
        int idx;
        int cyc;
        logic [7:0] exp;
        for (int i = 0; i < 16; i++) begin
            in_data  = base + tbl[i].din;
            in_valid = 1'b1;
`ifdef AES_SR_INV_MODE_EN
            inv_mode = (i == 0) ? inv : ~inv;
`endif
            check($sformatf("fill in_ready[%0d]", i), 32'(in_ready), 32'd1);
            check($sformatf("fill out_valid[%0d]", i), 32'(out_valid), 32'd0);
            check($sformatf("fill busy[%0d]", i), 32'(busy), 32'(i != 0));
            if (i != 0)
                check($sformatf("fill blk_done[%0d]", i), 32'(blk_done), 32'd0);
            @(posedge clk);
            #1;
        end
        in_valid = garbage;
        in_data  = 8'hAA;
        idx = 0;
        cyc = 0;
        while (idx < 16 && cyc < 200) begin
            out_ready = toggle ? (cyc % 2 == 0) : 1'b1;
            exp = base + (inv ? tbl[idx].exp_inv : tbl[idx].exp_fwd);
            check($sformatf("drain out_valid[%0d]", idx), 32'(out_valid), 32'd1);
            check($sformatf("drain out_data[%0d]", idx), 32'(out_data), 32'(exp));
            check($sformatf("drain in_ready[%0d]", idx), 32'(in_ready), 32'd0);
            check($sformatf("drain busy[%0d]", idx), 32'(busy), 32'd1);
            check($sformatf("drain blk_done[%0d]", idx), 32'(blk_done), 32'd0);
            @(posedge clk);
            #1;
            if (out_ready) idx++;
            cyc++;
        end
        check("drain completed within budget", 32'(idx), 32'd16);
        check("blk_done pulse", 32'(blk_done), 32'd1);
        check("post-block out_valid", 32'(out_valid), 32'd0);
        check("post-block in_ready", 32'(in_ready), 32'd1);
        check("post-block busy", 32'(busy), 32'd0);
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    initial begin
        logic [7:0] fwd [16];
        logic [7:0] inv [16];
        fwd = '{8'h00, 8'h05, 8'h0A, 8'h0F, 8'h04, 8'h09, 8'h0E, 8'h03,
                8'h08, 8'h0D, 8'h02, 8'h07, 8'h0C, 8'h01, 8'h06, 8'h0B};
        inv = '{8'h00, 8'h0D, 8'h0A, 8'h07, 8'h04, 8'h01, 8'h0E, 8'h0B,
                8'h08, 8'h05, 8'h02, 8'h0F, 8'h0C, 8'h09, 8'h06, 8'h03};
        for (int i = 0; i < 16; i++) begin
            tbl[i].din     = 8'(i);
            tbl[i].exp_fwd = fwd[i];
            tbl[i].exp_inv = inv[i];
        end

        rst       = 1'b1;
        in_data   = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
`ifdef AES_SR_INV_MODE_EN
        inv_mode  = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_reset_outputs("idle");

        // Free-running block
        run_block(8'h00, 1'b0, 1'b0, 1'b0);
        // Stalled every other cycle, out_data must hold
        run_block(8'h00, 1'b1, 1'b0, 1'b0);
        // Two back-to-back blocks
        run_block(8'h00, 1'b0, 1'b0, 1'b0);
        run_block(8'h10, 1'b0, 1'b0, 1'b0);
        // Garbage on in_data with in_valid held during drain
        run_block(8'h00, 1'b0, 1'b1, 1'b0);

        // Abort after 9 bytes with an asynchronous reset
        for (int i = 0; i < 9; i++) begin
            in_data  = 8'(8'h40 + i);
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            check($sformatf("abort blk_done[%0d]", i), 32'(blk_done), 32'd0);
        end
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("async reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_reset_outputs("after abort");
        run_block(8'h00, 1'b0, 1'b0, 1'b0);

`ifdef AES_SR_INV_MODE_EN
        run_block(8'h00, 1'b0, 1'b0, 1'b1);
        run_block(8'h00, 1'b1, 1'b0, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

endmodule
